isquare_pipe: RTL and testbench



---
 rtl/isquare_pipe.sv | 84 ++++++++
 tb/tb_isquare_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/isquare_pipe.sv
// Pipelined 16-bit integer squarer: x = y*y built from 16 shift-add slices,
// grouped into n_pipe_stages register stages with a run/ready valid flag.
module isquare_pipe #(
    parameter int unsigned n_pipe_stages = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] y,
    output logic        ready,
    output logic [31:0] x
);

    localparam int unsigned y_w              = 16;
    localparam int unsigned x_w              = 32;
    localparam int unsigned idx_w            = $clog2(y_w);
    localparam int unsigned slices_per_stage = y_w / n_pipe_stages;

    if (n_pipe_stages != 1 && n_pipe_stages != 2 && n_pipe_stages != 4 &&
        n_pipe_stages != 8 && n_pipe_stages != 16) begin : g_bad_param
        $error("isquare_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
    end

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
        localparam int unsigned base = 32'(s) * slices_per_stage;

        logic             in_valid;
        logic [y_w-1:0]   in_y;
        logic [x_w-1:0]   in_acc;
        logic [x_w-1:0]   acc_c;
        logic             valid_q;
        logic [x_w-1:0]   acc_q;

        // Stage inputs: the ports for the first stage, the previous stage's registers otherwise
        if (s == 0) begin : g_in
            assign in_valid = run;
            assign in_y     = y;
            assign in_acc   = '0;
        end else begin : g_in
            assign in_valid = g_stage[s-1].valid_q;
            assign in_y     = g_stage[s-1].g_fwd.y_q;
            assign in_acc   = g_stage[s-1].acc_q;
        end

        // Combinational shift-add slices of this group
        always_comb begin
            acc_c = in_acc;
            for (int unsigned k = 0; k < slices_per_stage; k++) begin
                if (in_y[idx_w'(base + k)]) begin
                    acc_c = acc_c + (x_w'(in_y) << (base + k));
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                acc_q   <= '0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    acc_q <= acc_c;
                end
            end
        end

        // The operand copy is only needed by later stages
        if (32'(s) + 1 < n_pipe_stages) begin : g_fwd
            logic [y_w-1:0] y_q;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    y_q <= '0;
                end else if (in_valid) begin
                    y_q <= in_y;
                end
            end
        end
    end

    assign ready = g_stage[n_pipe_stages-1].valid_q;
    assign x     = g_stage[n_pipe_stages-1].acc_q;

endmodule

// File: tb/tb_isquare_pipe.sv
// Scoreboard bench for isquare_pipe: all legal stage counts run side by side
// on a shared stimulus stream, with an integer square-root round-trip check.
module tb_isquare_pipe;

    typedef struct {
        logic [15:0] y;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] y = '0;
    logic        done = 1'b0;
    string       phase = "reset";

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned np,
                            input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s n=%0d: got 0x%08h, want 0x%08h", phase, tag, np, got, exp);
        end
    endtask

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'(1) << b);
            if (t * t <= 64'(v)) r = t;
        end
        return 16'(r);
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        localparam int unsigned np = 32'(1) << gi;

        logic        ready;
        logic [31:0] x;
        exp_t        q[$];
        int unsigned lc = 0;
        logic        armed = 1'b0;
        logic [31:0] last_x = '0;

        isquare_pipe #(.n_pipe_stages(np)) u_dut (
            .clock  (clk),
            .reset_n(reset_n),
            .run    (run),
            .y      (y),
            .ready  (ready),
            .x      (x)
        );

        // Capture launched operands with the cycle their result is due
        always @(posedge clk) begin
            lc++;
            if (!reset_n) begin
                q.delete();
                armed  = 1'b1;
                last_x = '0;
            end else if (run) begin
                q.push_back('{y: y, due: lc + np - 1});
            end
        end

        always @(negedge clk) begin
            logic exp_rdy;
            exp_t e;
            if (armed) begin
                exp_rdy = (q.size() != 0) && (q[0].due == lc);
                check_eq("ready", np, 32'(ready), 32'(exp_rdy));
                if (ready) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check_eq("x", np, x, 32'(e.y) * 32'(e.y));
                        check_eq("roundtrip", np, 32'(isqrt(x)), 32'(e.y));
                    end
                    last_x = x;
                end else begin
                    if (exp_rdy) void'(q.pop_front());
                    check_eq("hold", np, x, last_x);
                end
            end
        end

        initial begin
            wait (done);
            check_eq("drain", np, q.size(), 32'd0);
        end
    end

    task automatic drive(input logic rn, input logic r, input logic [15:0] v);
        @(negedge clk);
        reset_n = rn;
        run     = r;
        y       = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] corners[3];
        corners = '{16'h0000, 16'h0001, 16'hFFFF};

        phase = "reset";
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'h1234);
        idle(20);

        phase = "single";
        drive(1'b1, 1'b1, 16'd0);
        idle(20);
        drive(1'b1, 1'b1, 16'hFFFF);
        idle(20);
        drive(1'b1, 1'b1, 16'd46341);
        idle(20);

        phase = "stream";
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 16'(i));
        idle(20);

        phase = "bubble";
        drive(1'b1, 1'b1, 16'd10);
        drive(1'b1, 1'b0, 16'd99);
        drive(1'b1, 1'b1, 16'd20);
        idle(20);

        phase = "midreset";
        drive(1'b1, 1'b1, 16'd5);
        drive(1'b1, 1'b1, 16'd6);
        drive(1'b1, 1'b1, 16'd7);
        drive(1'b0, 1'b0, 16'd0);
        idle(20);
        drive(1'b1, 1'b1, 16'd8);
        idle(20);

        phase = "random";
        foreach (corners[i]) drive(1'b1, 1'b1, corners[i]);
        for (int i = 0; i < 10000; i++) begin
            drive(1'b1, 1'b1, 16'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0, 16'($urandom));
        end
        idle(20);

        phase = "end";
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
